// File: rtl/sig_filter_pkg.sv
// Shared constants for the sig_filter glitch filter and its optional input synchronizer.
package sig_filter_pkg;
    localparam int SIG_FILTER_DEPTH_DEF   = 4;
    localparam int SIG_FILTER_DEPTH_MAX   = 32;
    localparam int SIG_FILTER_SYNC_STAGES = 2;
endpackage

// File: rtl/sig_filter_if.sv
// Raw and filtered signal pair between the filter and its surroundings.
// The filter samples sig_in every clock and drives a registered sig_out; there is no handshake.
interface sig_filter_if;
    logic sig_in;
    logic sig_out;

    modport master (output sig_in, input sig_out);
    modport slave  (input sig_in, output sig_out);
endinterface

// File: rtl/sig_sync2.sv
// Two-flop synchronizer with both stages cleared to 0 by an asynchronous reset.
module sig_sync2
    import sig_filter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SIG_FILTER_SYNC_STAGES-1:0] ff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[SIG_FILTER_SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SIG_FILTER_SYNC_STAGES-1];

endmodule

// File: rtl/sig_filter.sv
// Single-bit glitch filter with hysteresis: sig_out follows sig_in only after DEPTH equal samples.
// Define SIG_FILTER_SYNC_EN to pass sig_in through a 2-flop synchronizer first.
module sig_filter
    import sig_filter_pkg::*;
#(
    parameter int DEPTH = SIG_FILTER_DEPTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    sig_filter_if.slave  flt
);

    if (DEPTH < 2 || DEPTH > SIG_FILTER_DEPTH_MAX) begin : g_bad_depth
        $error("sig_filter: DEPTH %0d outside 2..%0d", DEPTH, SIG_FILTER_DEPTH_MAX);
    end

    logic             s;
    logic [DEPTH-1:0] sr;
    logic             out_q;

`ifdef SIG_FILTER_SYNC_EN
    sig_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (flt.sig_in),
        .q     (s)
    );
`else
    assign s = flt.sig_in;
`endif

    // Decision looks at sr before this edge's shift, giving DEPTH+1 edges of latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr    <= '0;
            out_q <= 1'b0;
        end else begin
            sr <= {sr[DEPTH-2:0], s};
            if (&sr) begin
                out_q <= 1'b1;
            end else if (~|sr) begin
                out_q <= 1'b0;
            end
        end
    end

    assign flt.sig_out = out_q;

endmodule

// File: tb/tb_sig_filter.sv
// Directed bench for sig_filter at DEPTH=4: reset, latency, short/exact pulses, toggling, async reset.
module tb_sig_filter;

    localparam int DEPTH = 4;
`ifdef SIG_FILTER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LAT = DEPTH + 1 + SYNC_LAT;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];

    sig_filter_if flt_if ();

    sig_filter #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .flt   (flt_if)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold sig_in at val for n edges, checking the output stays at exp.
    task automatic hold(input logic val, input int n, input logic exp, input string tag);
        flt_if.sig_in = val;
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, flt_if.sig_out, exp);
        end
    endtask

    initial begin
        flt_if.sig_in = 1'b1;
        reset = 1'b1;
        #1;
        check("reset_out", flt_if.sig_out, 1'b0);

        // Reset held over 3 edges with input high.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", flt_if.sig_out, 1'b0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Rise after LAT edges from release.
        for (int k = 1; k <= LAT; k++) begin
            step();
            check("rise_lat", flt_if.sig_out, (k == LAT));
        end
        hold(1'b1, 3, 1'b1, "rise_stay");

        // Async reset mid-clock while output is high.
        #5;
        reset = 1'b1;
        #1;
        check("async_reset", flt_if.sig_out, 1'b0);
        step();
        check("async_reset_hold", flt_if.sig_out, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step();
            check("rerise_lat", flt_if.sig_out, (k == LAT));
        end

        // Short low glitch while high is suppressed.
        hold(1'b0, DEPTH - 1, 1'b1, "low_glitch");
        hold(1'b1, LAT + 2, 1'b1, "low_glitch_after");

        // Fall latency.
        flt_if.sig_in = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step();
            check("fall_lat", flt_if.sig_out, (k != LAT));
        end
        hold(1'b0, 4, 1'b0, "fall_stay");

        // DEPTH-1 high samples never change the output.
        hold(1'b1, DEPTH - 1, 1'b0, "short_pulse");
        hold(1'b0, LAT + 4, 1'b0, "short_pulse_after");

        // Exactly DEPTH high samples: high for DEPTH clocks, low 5 edges after first low sample.
        for (int k = 1; k <= LAT + 9; k++) begin
            exp_q.push_back((k >= LAT) && (k < LAT + 4));
        end
        for (int k = 1; k <= LAT + 9; k++) begin
            logic e;
            flt_if.sig_in = (k <= DEPTH);
            step();
            e = exp_q.pop_front();
            check("exact_pulse", flt_if.sig_out, e);
        end

        // Toggle every 1.5 clocks for 100 clocks, offset so no toggle meets an edge.
        flt_if.sig_in = 1'b0;
        @(posedge clock);
        fork
            begin
                #25;
                for (int j = 0; j < 66; j++) begin
                    flt_if.sig_in = ~flt_if.sig_in;
                    #30;
                end
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    step();
                    check("toggle", flt_if.sig_out, 1'b0);
                end
            end
        join
        flt_if.sig_in = 1'b0;
        hold(1'b0, LAT, 1'b0, "toggle_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
